// File: rtl/router_fsm.sv
// router_fsm: sequencing controller for the 1x3 router datapath.
// Decodes the header address, steps the register/parity block through its
// load phases, and generates the FIFO write enable and source-side busy.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   DA    | decode address: wait for a valid header, latch destination
//   LFD   | load first data: header byte written via the register block
//   LD    | load data: payload bytes written, source free-running
//   FFS   | fifo full: destination full, stall source and hold writes
//   LAF   | load after full: flush the byte held while the FIFO was full
//   LP    | load parity: parity byte written
//   CPE   | check parity error: clear internal register state
//   WTE   | wait till empty: destination still holds an older packet
module router_fsm #(
  parameter int NUM_PORTS = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic [1:0] dest_addr
);

  // With three ports the first unused address value marks an invalid header.
  localparam logic [1:0] ADDR_INVALID = 2'(NUM_PORTS);

  typedef enum logic [2:0] {
    S_DA  = 3'd0,
    S_LFD = 3'd1,
    S_LD  = 3'd2,
    S_FFS = 3'd3,
    S_LAF = 3'd4,
    S_LP  = 3'd5,
    S_CPE = 3'd6,
    S_WTE = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_dest_addr;
  logic       w_hdr_valid;
  logic       w_hdr_empty;
  logic       w_sel_empty;
  logic       w_sel_soft_reset;

  assign w_hdr_valid = pkt_valid && (data_in != ADDR_INVALID);

  // Empty flag of the port named by the header currently on data_in.
  always_comb begin
    w_hdr_empty = 1'b0;
    case (data_in)
      2'd0:    w_hdr_empty = fifo_empty_0;
      2'd1:    w_hdr_empty = fifo_empty_1;
      2'd2:    w_hdr_empty = fifo_empty_2;
      default: w_hdr_empty = 1'b0;
    endcase
  end

  // Empty flag and soft reset of the latched destination port.
  always_comb begin
    w_sel_empty      = 1'b0;
    w_sel_soft_reset = 1'b0;
    case (r_dest_addr)
      2'd0: begin
        w_sel_empty      = fifo_empty_0;
        w_sel_soft_reset = soft_reset_0;
      end
      2'd1: begin
        w_sel_empty      = fifo_empty_1;
        w_sel_soft_reset = soft_reset_1;
      end
      2'd2: begin
        w_sel_empty      = fifo_empty_2;
        w_sel_soft_reset = soft_reset_2;
      end
      default: begin
        w_sel_empty      = 1'b0;
        w_sel_soft_reset = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_DA;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Destination latch: captured only when a valid header is accepted in DA.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_dest_addr <= 2'd0;
    end else if ((r_state == S_DA) && w_hdr_valid) begin
      r_dest_addr <= data_in;
    end
  end

  // Next-state logic; a soft reset on the selected port overrides everything.
  always_comb begin
    w_next_state = r_state;
    if ((r_state != S_DA) && w_sel_soft_reset) begin
      w_next_state = S_DA;
    end else begin
      case (r_state)
        S_DA: begin
          if (w_hdr_valid) begin
            w_next_state = w_hdr_empty ? S_LFD : S_WTE;
          end
        end
        S_LFD: w_next_state = S_LD;
        S_LD: begin
          if (fifo_full) begin
            w_next_state = S_FFS;
          end else if (!pkt_valid) begin
            w_next_state = S_LP;
          end
        end
        S_FFS: begin
          if (!fifo_full) begin
            w_next_state = S_LAF;
          end
        end
        S_LAF: begin
          if (parity_done) begin
            w_next_state = S_DA;
          end else if (low_packet_valid) begin
            w_next_state = S_LP;
          end else begin
            w_next_state = S_LD;
          end
        end
        S_LP:  w_next_state = S_CPE;
        S_CPE: w_next_state = fifo_full ? S_FFS : S_DA;
        S_WTE: begin
          if (w_sel_empty) begin
            w_next_state = S_LFD;
          end
        end
        default: w_next_state = S_DA;
      endcase
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (r_state)
      S_DA: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      S_LFD: lfd_state = 1'b1;
      S_LD: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      S_FFS: full_state = 1'b1;
      S_LAF: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      S_LP:  write_enb_reg = 1'b1;
      S_CPE: rst_int_reg = 1'b1;
      S_WTE: busy = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign dest_addr = r_dest_addr;

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed scenarios plus a randomized
// run, all compared against a phase-level reference model of the router.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1;
  logic       fifo_empty_1 = 1'b1;
  logic       fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0;
  logic       soft_reset_1 = 1'b0;
  logic       soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_packet_valid = 1'b0;
  logic       busy, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, write_enb_reg;
  logic [1:0] dest_addr;

  router_fsm #(.NUM_PORTS(3)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .busy(busy), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .dest_addr(dest_addr)
  );

  always #5 clock = ~clock;

  // Packet phases of the reference model.
  localparam int PH_DA = 0, PH_LFD = 1, PH_LD = 2, PH_FFS = 3;
  localparam int PH_LAF = 4, PH_LP = 5, PH_CPE = 6, PH_WTE = 7;
  localparam logic [9:0] RESET_VEC = 10'b0100000000;

  logic [9:0] obs;
  assign obs = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, dest_addr};

  int         n_cmp = 0;
  int         n_fail = 0;
  int         m_ph = PH_DA;
  logic [1:0] m_addr = 2'd0;

  // Expected {busy, strobes, write enable, address} for a phase.
  function automatic logic [9:0] exp_vec(int ph, logic [1:0] a);
    logic [7:0] f;
    case (ph)
      PH_DA:   f = 8'b01000000;
      PH_LFD:  f = 8'b10100000;
      PH_LD:   f = 8'b00010001;
      PH_FFS:  f = 8'b10000100;
      PH_LAF:  f = 8'b10001001;
      PH_LP:   f = 8'b10000001;
      PH_CPE:  f = 8'b10000010;
      default: f = 8'b10000000;
    endcase
    return {f, a};
  endfunction

  // Packet-level rules: where the router goes next given current inputs.
  function automatic int model_next(int ph, logic [1:0] a);
    logic [3:0] e;
    logic [3:0] s;
    e = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    s = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    if (ph != PH_DA && s[a]) return PH_DA;
    case (ph)
      PH_DA: begin
        if (pkt_valid && data_in != 2'd3) return e[data_in] ? PH_LFD : PH_WTE;
        return PH_DA;
      end
      PH_LFD: return PH_LD;
      PH_LD:  return fifo_full ? PH_FFS : (!pkt_valid ? PH_LP : PH_LD);
      PH_FFS: return fifo_full ? PH_FFS : PH_LAF;
      PH_LAF: return parity_done ? PH_DA : (low_packet_valid ? PH_LP : PH_LD);
      PH_LP:  return PH_CPE;
      PH_CPE: return fifo_full ? PH_FFS : PH_DA;
      default: return e[a] ? PH_LFD : PH_WTE;
    endcase
  endfunction

  task automatic tick();
    int nph;
    @(posedge clock);
    if (resetn) begin
      nph = model_next(m_ph, m_addr);
      if (m_ph == PH_DA && pkt_valid && data_in != 2'd3) m_addr = data_in;
      m_ph = nph;
    end
    #1;
  endtask

  task automatic cyc(input logic pv, input logic [1:0] d, input logic f,
                     input logic [2:0] e, input logic [2:0] s,
                     input logic pd, input logic lpv);
    pkt_valid = pv; data_in = d; fifo_full = f;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = e;
    {soft_reset_2, soft_reset_1, soft_reset_0} = s;
    parity_done = pd; low_packet_valid = lpv;
    tick();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_state got=%b exp=%b", obs, RESET_VEC);
    end
    @(negedge clock); resetn = 1'b1;
    m_ph = PH_DA; m_addr = 2'd0;
    cyc(0, 0, 0, 3'b111, 0, 0, 0);
    n_cmp++;
    if (obs !== exp_vec(m_ph, m_addr)) begin
      n_fail++; $display("FAIL reset_idle got=%b exp=%b", obs, exp_vec(m_ph, m_addr));
    end
  endtask

  task automatic test_basic_packet();
    logic pv_seq [7] = '{1, 1, 1, 1, 0, 0, 0};
    int   we_cnt = 0;
    int   ld_busy = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(pv_seq[i], (i == 0) ? 2'd0 : 2'($urandom), 0, 3'b111, 0, 0, 0);
      n_cmp++;
      if (obs !== exp_vec(m_ph, m_addr)) begin
        n_fail++; $display("FAIL basic cyc%0d got=%b exp=%b", i, obs, exp_vec(m_ph, m_addr));
      end
      if (write_enb_reg) we_cnt++;
      if (ld_state && busy) ld_busy++;
    end
    n_cmp++;
    if (we_cnt != 4 || ld_busy != 0 || detect_add !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_totals got we=%0d ld_busy=%0d da=%b exp we=4 ld_busy=0 da=1",
               we_cnt, ld_busy, detect_add);
    end
  endtask

  task automatic test_wait_till_empty();
    int wte_cnt = 0;
    cyc(1, 2'd1, 0, 3'b101, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs !== exp_vec(m_ph, m_addr)) begin
        n_fail++; $display("FAIL wte cyc%0d got=%b exp=%b", i, obs, exp_vec(m_ph, m_addr));
      end
      if (busy && !detect_add && !lfd_state && !write_enb_reg && !full_state && !rst_int_reg)
        wte_cnt++;
      // data_in points at an empty port while waiting: only the latched port matters
      if (i < 4) cyc(1, 2'd0, 0, 3'b101, 0, 0, 0);
      else if (i < 6) cyc(1, 2'd0, 0, 3'b111, 0, 0, 0);
      else cyc(0, 2'd0, 0, 3'b111, 0, 0, 0);
    end
    n_cmp++;
    if (wte_cnt != 5 || dest_addr !== 2'd1) begin
      n_fail++; $display("FAIL wte_hold got cycles=%0d addr=%0d exp cycles=5 addr=1", wte_cnt, dest_addr);
    end
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 3'b111, 0, 0, 0);
  endtask

  task automatic test_fifo_full();
    logic f_seq [6] = '{0, 0, 1, 1, 1, 0};
    for (int lp = 0; lp < 2; lp++) begin
      int full_cnt = 0;
      cyc(1, 2'd2, 0, 3'b111, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (obs !== exp_vec(m_ph, m_addr)) begin
          n_fail++;
          $display("FAIL full lpv%0d cyc%0d got=%b exp=%b", lp, i, obs, exp_vec(m_ph, m_addr));
        end
        if (full_state) full_cnt++;
        if (i < 6) cyc(1, 2'($urandom), f_seq[i], 3'b111, 0, 0, 0);
        else if (i == 6) cyc(lp == 0, 2'd0, 0, 3'b111, 0, 0, 1'(lp));
        else cyc(0, 2'd0, 0, 3'b111, 0, 0, 0);
      end
      n_cmp++;
      if (full_cnt != 3) begin
        n_fail++; $display("FAIL full_count got=%0d exp=3", full_cnt);
      end
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 3'b111, 0, 0, 0);
  endtask

  task automatic test_invalid_addr();
    int stray = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(i < 4, (i < 4) ? 2'd3 : 2'd1, 0, 3'b111, 0, 0, 0);
      n_cmp++;
      if (obs !== exp_vec(m_ph, m_addr)) begin
        n_fail++; $display("FAIL invalid cyc%0d got=%b exp=%b", i, obs, exp_vec(m_ph, m_addr));
      end
      if (!detect_add || write_enb_reg || busy) stray++;
    end
    n_cmp++;
    if (stray != 0 || dest_addr !== 2'd2) begin
      n_fail++; $display("FAIL invalid_hold got stray=%0d addr=%0d exp stray=0 addr=2", stray, dest_addr);
    end
  endtask

  task automatic test_soft_reset();
    logic [2:0] s_seq [9] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
    logic       pv_seq [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 9; i++) begin
      cyc(pv_seq[i], 2'd1, 0, 3'b111, s_seq[i], 0, 0);
      n_cmp++;
      if (obs !== exp_vec(m_ph, m_addr)) begin
        n_fail++; $display("FAIL softrst cyc%0d got=%b exp=%b", i, obs, exp_vec(m_ph, m_addr));
      end
      if (i == 4) begin
        n_cmp++;
        if (busy !== 1'b0 || detect_add !== 1'b1) begin
          n_fail++; $display("FAIL softrst_to_da got busy=%b da=%b exp busy=0 da=1", busy, detect_add);
        end
      end
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 3'b111, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    int we_cnt = 0;
    cyc(1, 2'd0, 0, 3'b111, 0, 0, 0);
    cyc(1, 2'd0, 0, 3'b111, 0, 0, 0);
    cyc(1, 2'd0, 1, 3'b111, 0, 0, 0);
    cyc(1, 2'd0, 1, 3'b111, 0, 0, 0);
    n_cmp++;
    if (obs !== exp_vec(m_ph, m_addr) || full_state !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre got=%b exp=%b", obs, exp_vec(m_ph, m_addr));
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_fail++; $display("FAIL arst_immediate got=%b exp=%b", obs, RESET_VEC);
    end
    m_ph = PH_DA; m_addr = 2'd0;
    tick();
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_fail++; $display("FAIL arst_held got=%b exp=%b", obs, RESET_VEC);
    end
    @(negedge clock); resetn = 1'b1; fifo_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(i < 3, 2'd0, 0, 3'b111, 0, 0, 0);
      n_cmp++;
      if (obs !== exp_vec(m_ph, m_addr)) begin
        n_fail++; $display("FAIL arst_after cyc%0d got=%b exp=%b", i, obs, exp_vec(m_ph, m_addr));
      end
      if (write_enb_reg) we_cnt++;
    end
    n_cmp++;
    if (we_cnt != 3 || detect_add !== 1'b1) begin
      n_fail++; $display("FAIL arst_packet got we=%0d da=%b exp we=3 da=1", we_cnt, detect_add);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 15) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      cyc($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 3) == 0,
          3'($urandom), s, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      n_cmp++;
      if (obs !== exp_vec(m_ph, m_addr)) begin
        n_fail++; $display("FAIL random cyc%0d got=%b exp=%b", i, obs, exp_vec(m_ph, m_addr));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_wait_till_empty();
    test_fifo_full();
    test_invalid_addr();
    test_soft_reset();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
